systolic_pe_mac: RTL
====================

// Module: systolic_pe_mac
// PURPOSE
//  - Parametrised weight-stationary processing element for the systolic array; successor to the 32-bit float PE.
//  - Signed fixed-point MAC: ans = c_in + a_in * w_active.
//  - Activations flow west->east; partial sums flow north->south.
//  - Weights shift down a column chain into a shadow register and swap into the active register on `switch`,
//    so the next tile loads while the current tile computes.
// PARAMETERS
//  DW  8   activation/weight width, signed two's complement
//  AW  24  partial-sum width, signed; AW >= 2*DW required (elaboration-time $error otherwise)
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  a_in         in   DW  activation from west neighbour
//  a_valid_in   in   1   a_in qualifier
//  b_in         in   DW  weight-chain data from north neighbour
//  b_load_in    in   1   weight-chain shift enable
//  switch       in   1   promote shadow weight to active weight
//  c_in         in   AW  partial sum from north neighbour
//  a_out        out  DW  registered activation to east
//  a_valid_out  out  1   registered a_valid_in
//  b_out        out  DW  weight-chain data to south
//  b_load_out   out  1   registered b_load_in
//  ans          out  AW  partial sum to south
//  ans_valid    out  1   ans qualifier
//  w_active     out  DW  current active weight (debug / chain inspection)
//  ovf          out  1   sticky overflow flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): every output and internal register = 0, including shadow and active weights.
//    Reset asserted mid-operation discards any in-flight MAC and any partially shifted weight chain.
//  - All outputs are registered; latency is 1 cycle for the MAC, activation and weight paths.
//  - MAC, on a_valid_in=1:
//    - ans <= c_in + sext(a_in*w_active) computed at AW bits;
//    - ans_valid <= 1;
//    - a_out <= a_in; a_valid_out <= 1.
//  - a_valid_in=0: ans and a_out hold their last values; ans_valid <= 0 and a_valid_out <= 0.
//  - Product is full 2*DW signed, sign-extended to AW before the add.
//  - Weight chain, on b_load_in=1:
//    - shadow <= b_in; b_out <= old shadow; b_load_out <= 1;
//    - a column of N PEs is loaded with N beats, the bottom PE's weight first.
//  - b_load_in=0: shadow and b_out hold; b_load_out <= 0.
//  - switch=1 at an edge: active <= shadow (the old shadow value).
//    - A MAC in that same cycle uses the pre-switch active weight.
//  - switch and b_load_in in the same cycle: active takes the old shadow, shadow takes b_in. No beat is lost.
//  - switch asserted repeatedly without a load re-copies the same shadow value; this is harmless.
//  - The MAC, weight-chain and switch paths are independent; all may fire in one cycle.
// CONFIGURATION
//  SYSTOLIC_PE_SATURATE_EN defined:
//    - the sum is computed at AW+1 bits;
//    - on overflow, ans clamps to +2^(AW-1)-1 or -2^(AW-1), and ovf sets;
//    - ovf is sticky and clears only on reset.
//  SYSTOLIC_PE_SATURATE_EN undefined:
//    - ans wraps modulo 2^AW;
//    - ovf is tied to 0.
// TESTING (DW=8, AW=24)
//  1. Reset: drive rst_n=0 with random inputs -> all outputs 0 immediately, without waiting for a clk edge.
//     Release reset -> outputs still 0.
//  2. Basic MAC: b_in=5 with b_load_in for 1 cycle, then switch=1 for 1 cycle;
//     then a_in=3, c_in=10, a_valid_in=1 -> next cycle ans=25, ans_valid=1, a_out=3, w_active=5.
//  3. Simultaneous load/switch: shadow=5, active=2; assert b_load_in (b_in=7) + switch + a_valid_in (a_in=4, c_in=0) together
//     -> ans=8 (old weight 2), then w_active=5, shadow=7, b_out=5.
//  4. Signed extremes: w=-128, a=-128, c=0 -> ans=16384. w=-128, a=127, c=-1 -> ans=-16257.
//  5. Overflow: w=1, a=1, c=24'h7FFFFF -> ans=24'h800000 and ovf=0 without the macro;
//     ans=24'h7FFFFF and ovf=1 (sticky across later valid MACs) with the macro.
//  6. Reset mid-stream: assert rst_n=0 during a 3-beat weight shift with a_valid_in=1 -> all outputs 0.
//     After release, a fresh 1-beat load + switch produces correct MAC results.

Source files
------------

// File: rtl/systolic_pe_mac.sv
// systolic_pe_mac: weight-stationary processing element for the systolic array.
// Signed fixed-point MAC (ans = c_in + a_in * w_active), activations west->east,
// partial sums north->south. Weights shift down a column chain into a shadow
// register and are promoted to the active register on switch.
// Build option: define SYSTOLIC_PE_SATURATE_EN for a saturating sum with a
// sticky ovf flag; otherwise the sum wraps and ovf is tied low.
module systolic_pe_mac #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] a_in,
  input  logic          a_valid_in,
  input  logic [DW-1:0] b_in,
  input  logic          b_load_in,
  input  logic          switch,
  input  logic [AW-1:0] c_in,
  output logic [DW-1:0] a_out,
  output logic          a_valid_out,
  output logic [DW-1:0] b_out,
  output logic          b_load_out,
  output logic [AW-1:0] ans,
  output logic          ans_valid,
  output logic [DW-1:0] w_active,
  output logic          ovf
);

  if (AW < 2 * DW) begin : g_bad_width
    $error("systolic_pe_mac: AW must be at least 2*DW");
  end

  logic [DW-1:0] a_out_q, b_out_q, shadow_q, w_active_q;
  logic          a_valid_out_q, b_load_out_q, ans_valid_q;
  logic [AW-1:0] ans_q;

  // Full-precision signed product, sign-extended to the partial-sum width.
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic        [AW-1:0]   sum;

  assign prod     = $signed(a_in) * $signed(w_active_q);
  assign prod_ext = AW'(prod);

`ifdef SYSTOLIC_PE_SATURATE_EN
  localparam int unsigned SW = AW + 1;

  logic signed [AW:0] sum_wide;
  logic               sum_ovf;
  logic               ovf_q;

  // One guard bit detects overflow; clamp toward the sign of the true result.
  always_comb begin
    sum_wide = SW'($signed(c_in)) + SW'(prod_ext);
    sum_ovf  = sum_wide[AW] ^ sum_wide[AW-1];
    if (sum_ovf) begin
      sum = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      sum = sum_wide[AW-1:0];
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (a_valid_in && sum_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  // Wrapping sum modulo 2^AW.
  assign sum = c_in + prod_ext;
  assign ovf = 1'b0;
`endif

  // MAC and activation path: data holds when not valid, qualifiers follow a_valid_in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_q         <= '0;
      ans_valid_q   <= 1'b0;
      a_out_q       <= '0;
      a_valid_out_q <= 1'b0;
    end else begin
      ans_valid_q   <= a_valid_in;
      a_valid_out_q <= a_valid_in;
      if (a_valid_in) begin
        ans_q   <= sum;
        a_out_q <= a_in;
      end
    end
  end

  // Weight chain and shadow->active swap; both read the pre-edge shadow, so a
  // simultaneous load and switch loses no beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= '0;
      b_out_q      <= '0;
      b_load_out_q <= 1'b0;
      w_active_q   <= '0;
    end else begin
      b_load_out_q <= b_load_in;
      if (b_load_in) begin
        shadow_q <= b_in;
        b_out_q  <= shadow_q;
      end
      if (switch) begin
        w_active_q <= shadow_q;
      end
    end
  end

  assign a_out       = a_out_q;
  assign a_valid_out = a_valid_out_q;
  assign b_out       = b_out_q;
  assign b_load_out  = b_load_out_q;
  assign ans         = ans_q;
  assign ans_valid   = ans_valid_q;
  assign w_active    = w_active_q;

endmodule
